// File: rtl/uc_pkg.sv
// Shared types and encodings for the multicycle control unit.
package uc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB, S_LUI,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_BRANCH, S_JAL, S_ILLEGAL
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4,  ALU_SLT  = 4'd5,  ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL  = 4'd8,  ALU_SRA  = 4'd9,  ALU_PASS_B = 4'd10
  } alu_cmd_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RF_SRC_ALU = 2'd0;
  localparam logic [1:0] RF_SRC_MEM = 2'd1;
  localparam logic [1:0] RF_SRC_PC4 = 2'd2;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_MSB  = 1;
  localparam int FLAG_OVF  = 2;

  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;
  localparam logic [2:0] F3_BLT = 3'd4;
  localparam logic [2:0] F3_BGE = 3'd5;

endpackage

// File: rtl/uc_multiciclo_alu_dec.sv
// funct3/funct7 -> ALU command; only R-type uses funct7[5] to pick SUB.
module alu_dec
  import uc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       is_r,
  output alu_cmd_t   alu_cmd
);

  always_comb begin
    alu_cmd = ALU_ADD;
    case (funct3)
      3'd0: alu_cmd = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'd1: alu_cmd = ALU_SLL;
      3'd2: alu_cmd = ALU_SLT;
      3'd3: alu_cmd = ALU_SLTU;
      3'd4: alu_cmd = ALU_XOR;
      3'd5: alu_cmd = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'd6: alu_cmd = ALU_OR;
      3'd7: alu_cmd = ALU_AND;
      default: alu_cmd = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle RISC-V control unit with retired-instruction counter.
// ILLEGAL_TRAP_EN: illegal opcodes lock the unit with a sticky trap instead of retiring as NOPs.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [3:0]       alu_flags,
  input  logic             i_mem_ready,
  input  logic             d_mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             rf_we,
  output logic [1:0]       rf_src,
  output logic             alu_src,
  output logic [3:0]       alu_cmd,
  output logic             d_mem_we,
  output logic             d_mem_re,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);

  state_t   state, next_state;
  alu_cmd_t dec_cmd, cmd, cmd_q;
  logic     src_q;
  logic     lt, taken;
  logic     unused_bits;

  assign unused_bits = ^{funct7[6], funct7[4:0], alu_flags[3]};

  alu_dec u_alu_dec (
    .funct3    (funct3),
    .funct7_b5 (funct7[5]),
    .is_r      (state == S_EXEC_R),
    .alu_cmd   (dec_cmd)
  );

  assign lt = alu_flags[FLAG_MSB] ^ alu_flags[FLAG_OVF];

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = alu_flags[FLAG_ZERO];
      F3_BNE:  taken = !alu_flags[FLAG_ZERO];
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    rf_we      = 1'b0;
    rf_src     = RF_SRC_ALU;
    alu_src    = 1'b0;
    cmd        = ALU_ADD;
    d_mem_we   = 1'b0;
    d_mem_re   = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_FETCH: if (i_mem_ready) begin
        ir_we      = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: case (opcode)
        OP_R:              next_state = S_EXEC_R;
        OP_I:              next_state = S_EXEC_I;
        OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
        OP_BRANCH:         next_state = S_BRANCH;
        OP_JAL:            next_state = S_JAL;
        OP_LUI:            next_state = S_LUI;
        default:           next_state = S_ILLEGAL;
      endcase
      S_EXEC_R, S_EXEC_I: begin
        alu_src    = (state == S_EXEC_I);
        cmd        = dec_cmd;
        next_state = S_WB;
      end
      // ALU controls replay the EXEC cycle so the result stays stable while written
      S_WB: begin
        alu_src    = src_q;
        cmd        = cmd_q;
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_LUI: begin
        alu_src    = 1'b1;
        cmd        = ALU_PASS_B;
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src    = 1'b1;
        next_state = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        d_mem_re = 1'b1;
        if (d_mem_ready) begin
          rf_we      = 1'b1;
          rf_src     = RF_SRC_MEM;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_MEM_WR: begin
        d_mem_we = 1'b1;
        if (d_mem_ready) begin
          pc_we      = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_BRANCH: begin
        cmd        = ALU_SUB;
        pc_we      = 1'b1;
        pc_src     = taken;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        rf_we      = 1'b1;
        rf_src     = RF_SRC_PC4;
        pc_we      = 1'b1;
        pc_src     = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        next_state = S_ILLEGAL;
`else
        pc_we      = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
`endif
      end
      default: next_state = S_FETCH;
    endcase
  end

  assign alu_cmd = cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      instret <= '0;
      cmd_q   <= ALU_ADD;
      src_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (instr_done) instret <= instret + CNT_W'(1);
      if (state == S_EXEC_R || state == S_EXEC_I) begin
        cmd_q <= dec_cmd;
        src_q <= (state == S_EXEC_I);
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk) begin
    if (rst)                          trap_q <= 1'b0;
    else if (next_state == S_ILLEGAL) trap_q <= 1'b1;
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: vector table plus hand-written multicycle sequences.
module tb_uc_multiciclo;

  logic        clk, rst;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [3:0]  alu_flags;
  logic        i_mem_ready, d_mem_ready;
  logic        ir_we, pc_we, pc_src, rf_we, alu_src, d_mem_we, d_mem_re, instr_done, trap;
  logic [1:0]  rf_src;
  logic [3:0]  alu_cmd;
  logic [15:0] instret;
  logic        ir_we4, pc_we4, pc_src4, rf_we4, alu_src4, d_mem_we4, d_mem_re4, instr_done4, trap4;
  logic [1:0]  rf_src4;
  logic [3:0]  alu_cmd4;
  logic [3:0]  instret4;

  uc_multiciclo #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_flags(alu_flags), .i_mem_ready(i_mem_ready), .d_mem_ready(d_mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .rf_src(rf_src),
    .alu_src(alu_src), .alu_cmd(alu_cmd), .d_mem_we(d_mem_we), .d_mem_re(d_mem_re),
    .instr_done(instr_done), .instret(instret), .trap(trap)
  );

  uc_multiciclo #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_flags(alu_flags), .i_mem_ready(i_mem_ready), .d_mem_ready(d_mem_ready),
    .ir_we(ir_we4), .pc_we(pc_we4), .pc_src(pc_src4), .rf_we(rf_we4), .rf_src(rf_src4),
    .alu_src(alu_src4), .alu_cmd(alu_cmd4), .d_mem_we(d_mem_we4), .d_mem_re(d_mem_re4),
    .instr_done(instr_done4), .instret(instret4), .trap(trap4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] fl;
    int         cyc;
    int         cmd;
    int         src;
    int         rfwe;
    int         rfs;
    int         pcs;
  } vec_t;

  vec_t vecs[22];
  int n_chk = 0, n_fail = 0;
  int exp_ret = 0;
  int r_cyc, r_done, r_irwe_cnt, r_irwe_first, r_pcwe_cnt, r_rfwe_cnt, r_re_cnt, r_we_cnt;
  int r_cmd, r_src, r_rfs, r_pcs;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH until instr_done; mem_wait = not-ready cycles on the data side.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [3:0] fl, input int mem_wait);
    int mem_cnt;
    mem_cnt = 0;
    r_cyc = 0; r_done = 0; r_irwe_cnt = 0; r_irwe_first = 0;
    r_pcwe_cnt = 0; r_rfwe_cnt = 0; r_re_cnt = 0; r_we_cnt = 0;
    r_cmd = 0; r_src = 0; r_rfs = 0; r_pcs = 0;
    opcode = op; funct3 = f3; funct7 = f7; alu_flags = fl; i_mem_ready = 1'b1;
    for (int c = 1; c <= 30 && r_done == 0; c++) begin
      d_mem_ready = 1'b0;
      #1;
      if (d_mem_re || d_mem_we) begin
        d_mem_ready = (mem_cnt >= mem_wait);
        mem_cnt++;
        #1;
      end
      if (ir_we) begin
        r_irwe_cnt++;
        if (c == 1) r_irwe_first = 1;
      end
      if (pc_we)    r_pcwe_cnt++;
      if (rf_we)    r_rfwe_cnt++;
      if (d_mem_re) r_re_cnt++;
      if (d_mem_we) r_we_cnt++;
      if (instr_done) begin
        r_done = 1; r_cyc = c;
        r_cmd = int'(alu_cmd); r_src = int'(alu_src); r_rfs = int'(rf_src); r_pcs = int'(pc_src);
      end
      tick();
    end
    d_mem_ready = 1'b0;
    chk("retire_seen", r_done, 1);
    if (r_done != 0) exp_ret = (exp_ret + 1) % 65536;
  endtask

  initial begin
    vecs = '{
      '{7'b0110011, 3'd0, 7'h00, 4'b0000, 4,  0, 0, 1, 0, 0},  // add
      '{7'b0110011, 3'd0, 7'h20, 4'b0000, 4,  1, 0, 1, 0, 0},  // sub
      '{7'b0110011, 3'd5, 7'h20, 4'b0000, 4,  9, 0, 1, 0, 0},  // sra
      '{7'b0110011, 3'd5, 7'h00, 4'b0000, 4,  8, 0, 1, 0, 0},  // srl
      '{7'b0110011, 3'd7, 7'h00, 4'b0000, 4,  2, 0, 1, 0, 0},  // and
      '{7'b0110011, 3'd6, 7'h00, 4'b0000, 4,  3, 0, 1, 0, 0},  // or
      '{7'b0110011, 3'd4, 7'h00, 4'b0000, 4,  4, 0, 1, 0, 0},  // xor
      '{7'b0110011, 3'd1, 7'h00, 4'b0000, 4,  7, 0, 1, 0, 0},  // sll
      '{7'b0110011, 3'd3, 7'h00, 4'b0000, 4,  6, 0, 1, 0, 0},  // sltu
      '{7'b0010011, 3'd0, 7'h20, 4'b0000, 4,  0, 1, 1, 0, 0},  // addi, imm bit must not make SUB
      '{7'b0010011, 3'd5, 7'h20, 4'b0000, 4,  9, 1, 1, 0, 0},  // srai
      '{7'b0010011, 3'd2, 7'h00, 4'b0000, 4,  5, 1, 1, 0, 0},  // slti
      '{7'b0110111, 3'd0, 7'h00, 4'b0000, 3, 10, 1, 1, 0, 0},  // lui
      '{7'b1101111, 3'd0, 7'h00, 4'b0000, 3,  0, 0, 1, 2, 1},  // jal
      '{7'b1100011, 3'd0, 7'h00, 4'b0001, 3,  1, 0, 0, 0, 1},  // beq zero
      '{7'b1100011, 3'd1, 7'h00, 4'b0001, 3,  1, 0, 0, 0, 0},  // bne zero
      '{7'b1100011, 3'd4, 7'h00, 4'b0110, 3,  1, 0, 0, 0, 0},  // blt msb^ovf=0
      '{7'b1100011, 3'd4, 7'h00, 4'b0010, 3,  1, 0, 0, 0, 1},  // blt msb^ovf=1
      '{7'b1100011, 3'd5, 7'h00, 4'b0110, 3,  1, 0, 0, 0, 1},  // bge
      '{7'b1100011, 3'd2, 7'h00, 4'b0001, 3,  1, 0, 0, 0, 0},  // bad funct3
      '{7'b0000011, 3'd2, 7'h00, 4'b0000, 4,  0, 0, 1, 1, 0},  // lw
      '{7'b0100011, 3'd2, 7'h00, 4'b0000, 4,  0, 0, 0, 0, 0}   // sw
    };

    rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; alu_flags = '0;
    i_mem_ready = 1'b0; d_mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_instret", int'(instret), 0);
    chk("rst_trap", int'(trap), 0);
    chk("rst_ir_we", int'(ir_we), 0);
    chk("rst_pc_we", int'(pc_we), 0);
    tick();
    chk("fetch_hold_ir_we", int'(ir_we), 0);
    i_mem_ready = 1'b1;
    #1;
    chk("fetch_ready_ir_we", int'(ir_we), 1);
    i_mem_ready = 1'b0;
    #1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].fl, 0);
      chk($sformatf("v%0d_cycles", i), r_cyc, vecs[i].cyc);
      chk($sformatf("v%0d_ir_we_first", i), r_irwe_first, 1);
      chk($sformatf("v%0d_ir_we_cnt", i), r_irwe_cnt, 1);
      chk($sformatf("v%0d_pc_we_cnt", i), r_pcwe_cnt, 1);
      chk($sformatf("v%0d_rf_we_cnt", i), r_rfwe_cnt, vecs[i].rfwe);
      chk($sformatf("v%0d_alu_cmd", i), r_cmd, vecs[i].cmd);
      chk($sformatf("v%0d_alu_src", i), r_src, vecs[i].src);
      chk($sformatf("v%0d_rf_src", i), r_rfs, vecs[i].rfs);
      chk($sformatf("v%0d_pc_src", i), r_pcs, vecs[i].pcs);
      chk($sformatf("v%0d_instret", i), int'(instret), exp_ret);
    end
    chk("trap_clear", int'(trap), 0);

    // load with three not-ready cycles
    run_instr(7'b0000011, 3'd2, 7'h00, 4'b0000, 3);
    chk("ldw_cycles", r_cyc, 7);
    chk("ldw_re_cnt", r_re_cnt, 4);
    chk("ldw_rf_we_cnt", r_rfwe_cnt, 1);
    chk("ldw_pc_we_cnt", r_pcwe_cnt, 1);
    chk("ldw_rf_src", r_rfs, 1);
    chk("ldw_instret", int'(instret), exp_ret);

    // store with a second wait stalled, then reset mid-access
    opcode = 7'b0100011; funct3 = 3'd2; funct7 = '0; i_mem_ready = 1'b1; d_mem_ready = 1'b0;
    #1;
    tick(); tick(); tick();
    chk("stw_we_wait1", int'(d_mem_we), 1);
    chk("stw_pc_we_wait1", int'(pc_we), 0);
    tick();
    chk("stw_we_wait2", int'(d_mem_we), 1);
    chk("stw_instret_pre", int'(instret), exp_ret);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstw_d_mem_we", int'(d_mem_we), 0);
    chk("rstw_instret", int'(instret), 0);
    chk("rstw_fetch_ir_we", int'(ir_we), 1);
    i_mem_ready = 1'b0;
    #1;
    exp_ret = 0;

    // 16 addi x0 NOPs: the 4-bit counter wraps back to zero
    for (int k = 0; k < 16; k++) begin
      run_instr(7'b0010011, 3'd0, 7'h00, 4'b0000, 0);
      if (k == 14) chk("wrap_at_15", int'(instret4), 15);
    end
    chk("wrap_to_0", int'(instret4), 0);
    chk("wrap_wide", int'(instret), exp_ret);

`ifdef ILLEGAL_TRAP_EN
    opcode = 7'b1111111; funct3 = '0; funct7 = '0; i_mem_ready = 1'b1;
    #1;
    tick(); tick();
    chk("ill_trap", int'(trap), 1);
    tick(); tick(); tick();
    chk("ill_trap_sticky", int'(trap), 1);
    chk("ill_pc_we", int'(pc_we), 0);
    chk("ill_done", int'(instr_done), 0);
    chk("ill_instret_frozen", int'(instret), exp_ret);
`else
    run_instr(7'b1111111, 3'd0, 7'h00, 4'b0000, 0);
    chk("ill_cycles", r_cyc, 3);
    chk("ill_pc_we_cnt", r_pcwe_cnt, 1);
    chk("ill_rf_we_cnt", r_rfwe_cnt, 0);
    chk("ill_pc_src", r_pcs, 0);
    chk("ill_instret", int'(instret), exp_ret);
    chk("ill_trap", int'(trap), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Multicycle control unit that drives the RISC-V datapath (fd) from the other side of its control/status interface.
- Consumes opcode/funct3/funct7 and ALU flags; produces register-file, memory, ALU and PC control.
- Sequences FETCH→DECODE→EXEC→MEM/WB per instruction, with ready handshakes on instruction and data memory.
- Keeps a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter instret (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
opcode  in  7  instr[6:0] from fd
funct3  in  3  instr[14:12]
funct7  in  7  instr[31:25]
alu_flags  in  4  [0]=zero, [1]=MSB, [2]=overflow, [3]=unused (ignored)
i_mem_ready  in  1  instruction memory data valid this cycle
d_mem_ready  in  1  data memory access complete this cycle
ir_we  out  1  load instruction register
pc_we  out  1  update PC
pc_src  out  1  0=PC+4, 1=PC+imm
rf_we  out  1  register file write
rf_src  out  2  0=ALU, 1=d_mem_data, 2=PC+4, 3=reserved
alu_src  out  1  0=rs2, 1=immediate
alu_cmd  out  4  ALU operation (package encoding)
d_mem_we  out  1  data memory write strobe
d_mem_re  out  1  data memory read strobe
instr_done  out  1  one-cycle pulse on retire
instret  out  CNT_W  retired-instruction count
trap  out  1  sticky illegal-instruction flag

Behaviour:
- Reset (rst=1 at clk edge): state=FETCH, instret=0, trap=0. Any state is abandoned immediately, including mid-memory access.
- Default values in every state: strobes/enables 0, alu_cmd=ADD, alu_src=0, rf_src=0, pc_src=0.
- FETCH:
  - Hold while i_mem_ready=0.
  - When i_mem_ready=1: ir_we=1, then go to DECODE.
- DECODE: one cycle, no strobes. Dispatch on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - anything else → ILLEGAL
- EXEC_R / EXEC_I: alu_src=0 for EXEC_R, 1 for EXEC_I. alu_cmd decoded from funct3, plus funct7[5] for:
  - R-type: ADD/SUB
  - R and I types: SRL/SRA
  - Next state: WB.
- WB: rf_we=1, rf_src=0, pc_we=1, pc_src=0, instr_done=1 → FETCH. alu_cmd and alu_src are held from the previous state.
- LUI: alu_cmd=PASS_B, alu_src=1, rf_we=1, pc_we=1, instr_done=1 → FETCH.
- MEM_ADDR: alu_src=1, alu_cmd=ADD. Next state is MEM_RD for loads, MEM_WR for stores.
- MEM_RD:
  - d_mem_re=1 held while d_mem_ready=0.
  - On ready: rf_we=1, rf_src=1, pc_we=1, instr_done=1 → FETCH.
- MEM_WR:
  - d_mem_we=1 held while d_mem_ready=0.
  - On ready: pc_we=1, instr_done=1 → FETCH.
- BRANCH: single cycle; alu_cmd=SUB, alu_src=0; flags are sampled combinationally in the same cycle.
  - Conditions: beq=zero, bne=!zero, blt=MSB^overflow, bge=!(MSB^overflow).
  - Any other funct3 is treated as not-taken.
  - Outputs: pc_we=1, pc_src=taken, instr_done=1 → FETCH.
- JAL: rf_we=1, rf_src=2, pc_we=1, pc_src=1, instr_done=1 → FETCH.
- instret increments on every instr_done and wraps from 2^CNT_W-1 to 0.
- Minimum cycles per instruction (ready held high): R/I=4, load/store=4, branch/JAL/LUI=3.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: the ILLEGAL state sets trap=1 and stays in ILLEGAL with all strobes 0 until rst; instret is frozen.
- Undefined: ILLEGAL behaves as a NOP: pc_we=1, pc_src=0, instr_done=1 → FETCH. The trap output is tied to 0.

Decomposition:
- Package uc_pkg holds:
  - state enum
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI)
  - alu_cmd encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, PASS_B=10
  - rf_src encodings
  - flag bit indices
- One sub-module, alu_dec: combinational mapping of funct3/funct7/type to alu_cmd.

Test Plan:
- add (opcode 0110011, funct3=0, funct7=0), ready=1 always → ir_we at cycle 1, rf_we+pc_we+instr_done at cycle 4, alu_cmd=0, instret 0→1.
- ld with d_mem_ready low for 3 cycles → d_mem_re high 4 cycles, a single rf_we with rf_src=1 on the ready cycle, no earlier pc_we.
- beq with alu_flags=0001 → pc_src=1; bne with the same flags → pc_src=0; blt with flags MSB=1, overflow=1 → not taken.
- opcode 1111111:
  - With ILLEGAL_TRAP_EN: trap=1 stays set and instret stops incrementing.
  - Without it: pc_we=1, pc_src=0, instret increments.
- rst asserted during MEM_WR wait → next cycle d_mem_we=0, state=FETCH, instret=0.
- CNT_W=4, 16 retired NOPs (addi x0) → instret wraps from 15 to 0.
